// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction fetch and data access paths.
// Data accesses win, but a fetch is forced after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        ramready,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload
);

    // state | meaning
    // IDLE  | no access on the RAM port; grant decision made from this cycle's requests
    // IACC  | instruction fetch presented to RAM, waiting for ramready
    // DACC  | data load/store presented to RAM, waiting for ramready
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        wr_q, wr_d;
    logic [3:0]  starve_q, starve_d;
    logic        d_req;

    assign d_req = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        starve_d = starve_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = d_req;
        iload    = '0;
        dload    = '0;

        case (state_q)
            IDLE: begin
                if (!iREN)
                    starve_d = '0;
                if (d_req && (!iREN || starve_q < LIMIT)) begin
                    state_d = DACC;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else if (iREN) begin
                    state_d = IACC;
                    addr_d  = iaddr;
                end
            end
            IACC: begin
                // A dropped request aborts; a coincident ramready is ignored.
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = addr_q;
                    if (ramready) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        starve_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            DACC: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ramREN   = !wr_q;
                    ramWEN   = wr_q;
                    ramaddr  = addr_q;
                    ramstore = wr_q ? store_q : '0;
                    if (ramready) begin
                        dwait   = 1'b0;
                        dload   = wr_q ? '0 : ramload;
                        state_d = IDLE;
                        if (iREN && starve_q != 4'hF)
                            starve_d = starve_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
